// File: rtl/acia_pkg.sv
// rtl/acia_pkg.sv - register map, FSM state types, status bit indices and baud divider table
package acia_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CMD    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int ST_IRQ   = 7;
  localparam int ST_TDRE  = 4;
  localparam int ST_RDRF  = 3;
  localparam int ST_OVRN  = 2;
  localparam int ST_FRAME = 1;

  localparam int DIV_W = 16;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // round(clk_hz / (16 * baud)) with baud given in tenths to cover 109.92 and 134.58
  function automatic logic [DIV_W-1:0] div_round(input int unsigned clk_hz,
                                                 input int unsigned baud_x10);
    logic [63:0] q;
    q = (64'(clk_hz) * 64'd10 + 64'(baud_x10) * 64'd8) / (64'(baud_x10) * 64'd16);
    return DIV_W'(q);
  endfunction

  function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz,
                                                input logic [3:0] sel);
    case (sel)
      4'h1:    return div_round(clk_hz, 500);
      4'h2:    return div_round(clk_hz, 750);
      4'h3:    return div_round(clk_hz, 1099);
      4'h4:    return div_round(clk_hz, 1346);
      4'h5:    return div_round(clk_hz, 1500);
      4'h6:    return div_round(clk_hz, 3000);
      4'h7:    return div_round(clk_hz, 6000);
      4'h8:    return div_round(clk_hz, 12000);
      4'h9:    return div_round(clk_hz, 18000);
      4'hA:    return div_round(clk_hz, 24000);
      4'hB:    return div_round(clk_hz, 36000);
      4'hC:    return div_round(clk_hz, 48000);
      4'hD:    return div_round(clk_hz, 72000);
      4'hE:    return div_round(clk_hz, 96000);
      4'hF:    return div_round(clk_hz, 192000);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/acia_baudgen.sv
// rtl/acia_baudgen.sv - one-clk-wide 16x baud tick from the control rate select
module acia_baudgen
  import acia_pkg::*;
#(
  parameter int unsigned CLK_HZ = 42954000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sel,
  output logic       tick
);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sel_q, sel_d;
  logic             tick_q, tick_d;

  always_comb begin
    div    = baud_div(CLK_HZ, sel);
    cnt_d  = cnt_q;
    sel_d  = sel;
    tick_d = 1'b0;
    if (sel == 4'h0) begin
      cnt_d = '0;
    end else if (sel != sel_q) begin
      // a new rate restarts the period so the first tick is a full period away
      cnt_d = div - 16'd1;
    end else if (cnt_q == '0) begin
      tick_d = 1'b1;
      cnt_d  = div - 16'd1;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      sel_q  <= 4'h0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/acia6551.sv
// rtl/acia6551.sv - 6551-style ACIA: CPU register file, 8N1 receiver and transmitter
module acia6551
  import acia_pkg::*;
#(
  parameter int unsigned CLK_HZ = 42954000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_ena,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       rxd,
  output logic       txd,
  output logic       irq
);

  logic [7:0] ctrl_q, ctrl_d, cmd_q, cmd_d, thr_q, thr_d, rx_data_q, rx_data_d;
  logic       tdre_q, tdre_d, rdrf_q, rdrf_d, ovrn_q, ovrn_d, frame_q, frame_d;
  logic       rd_data_q, rd_data_d, rxd_meta_q, rxd_meta_d, rxd_sync_q, rxd_sync_d;
  rx_state_t  rx_state_q, rx_state_d;
  logic [3:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  tx_state_t  tx_state_q, tx_state_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       txd_q, txd_d;
  logic       tick, wr_en, rd_done, tx_load;

  acia_baudgen #(.CLK_HZ(CLK_HZ)) u_baudgen (
    .clk   (clk),
    .reset (reset),
    .sel   (ctrl_q[3:0]),
    .tick  (tick)
  );

  assign wr_en   = clk_ena & cs & we;
  assign rd_done = rd_data_q & ~cs;
  assign irq     = (rdrf_q & cmd_q[0] & ~cmd_q[1]) | (tdre_q & (cmd_q[3:2] == 2'b01));

  always_comb begin
    data_out = '0;
    case (addr)
      ADDR_DATA: data_out = rx_data_q;
      ADDR_STATUS: begin
        data_out[ST_IRQ]   = irq;
        data_out[ST_TDRE]  = tdre_q;
        data_out[ST_RDRF]  = rdrf_q;
        data_out[ST_OVRN]  = ovrn_q;
        data_out[ST_FRAME] = frame_q;
      end
      ADDR_CMD:  data_out = cmd_q;
      default:   data_out = ctrl_q;
    endcase
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    cmd_d      = cmd_q;
    thr_d      = thr_q;
    rx_data_d  = rx_data_q;
    tdre_d     = tdre_q;
    rdrf_d     = rdrf_q;
    ovrn_d     = ovrn_q;
    frame_d    = frame_q;
    rd_data_d  = cs & ~we & (addr == ADDR_DATA);
    rxd_meta_d = rxd;
    rxd_sync_d = rxd_meta_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_load    = 1'b0;
    txd_d      = 1'b1;

    // read clears land before the receiver so a coinciding frame loads cleanly
    if (rd_done) begin
      rdrf_d  = 1'b0;
      ovrn_d  = 1'b0;
      frame_d = 1'b0;
    end

    if (!cmd_q[0]) begin
      rx_state_d = RX_IDLE;
    end else if (tick) begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!rxd_sync_q) begin
            rx_state_d = RX_START;
            rx_cnt_d   = 4'd0;
          end
        end
        RX_START: begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd7) begin
            rx_cnt_d   = 4'd0;
            rx_bit_d   = 3'd0;
            rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd15) begin
            rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          end
        end
        default: begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd15) begin
            rx_state_d = RX_IDLE;
            if (!rxd_sync_q) frame_d = 1'b1;
            if (!rdrf_d) begin
              rx_data_d = rx_shift_q;
              rdrf_d    = 1'b1;
            end else begin
              ovrn_d = 1'b1;
            end
          end
        end
      endcase
    end

    if (tick) begin
      case (tx_state_q)
        TX_IDLE: tx_load = ~tdre_q & cmd_q[0];
        TX_START: begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            tx_state_d = TX_DATA;
            tx_bit_d   = 3'd0;
          end
        end
        TX_DATA: begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          end
        end
        default: begin
          tx_cnt_d = tx_cnt_q + 4'd1;
          if (tx_cnt_q == 4'd15) begin
            tx_state_d = TX_IDLE;
            tx_load    = ~tdre_q & cmd_q[0];
          end
        end
      endcase
    end

    if (tx_load) begin
      tx_state_d = TX_START;
      tx_cnt_d   = 4'd0;
      tx_shift_d = thr_q;
      tdre_d     = 1'b1;
    end

    case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase

    // CPU writes last: a data write racing the transfer keeps its byte pending
    if (wr_en) begin
      case (addr)
        ADDR_DATA: begin
          thr_d  = data_in;
          tdre_d = 1'b0;
        end
        ADDR_STATUS: begin
          cmd_d   = 8'h00;
          ovrn_d  = 1'b0;
          frame_d = 1'b0;
        end
        ADDR_CMD: cmd_d  = data_in;
        default:  ctrl_d = data_in;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= 8'h00;
      cmd_q      <= 8'h00;
      thr_q      <= 8'h00;
      rx_data_q  <= 8'h00;
      tdre_q     <= 1'b1;
      rdrf_q     <= 1'b0;
      ovrn_q     <= 1'b0;
      frame_q    <= 1'b0;
      rd_data_q  <= 1'b0;
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      txd_q      <= 1'b1;
    end else begin
      ctrl_q     <= ctrl_d;
      cmd_q      <= cmd_d;
      thr_q      <= thr_d;
      rx_data_q  <= rx_data_d;
      tdre_q     <= tdre_d;
      rdrf_q     <= rdrf_d;
      ovrn_q     <= ovrn_d;
      frame_q    <= frame_d;
      rd_data_q  <= rd_data_d;
      rxd_meta_q <= rxd_meta_d;
      rxd_sync_q <= rxd_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_acia6551.sv
// tb/tb_acia6551.sv - directed self-checking bench for acia6551
module tb_acia6551;

  // CLK_HZ / 10: 19200 baud -> 14 clk per tick (224 per bit), 9600 -> 28 (448 per bit)
  localparam int unsigned CLK_HZ = 4295400;
  localparam int TX_BIT = 224;
  localparam int RX_BIT = 448;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_ena = 1'b0;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       rxd = 1'b1;
  logic       txd;
  logic       irq;

  int errors = 0;
  int checks = 0;

  acia6551 #(.CLK_HZ(CLK_HZ)) dut (
    .clk      (clk),
    .reset    (reset),
    .clk_ena  (clk_ena),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .rxd      (rxd),
    .txd      (txd),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; clk_ena = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; clk_ena = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; clk_ena = 1'b1; addr = a;
    #1 d = data_out;
    @(negedge clk);
    cs = 1'b0; clk_ena = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (RX_BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (RX_BIT) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (RX_BIT) @(negedge clk);
    rxd = 1'b1;
    repeat (RX_BIT) @(negedge clk);
  endtask

  task automatic wait_txd_low(output logic found);
    int n;
    found = 1'b0;
    n = 0;
    while (!found && n < 2000) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
      n++;
    end
  endtask

  logic [7:0] rd;
  logic       found;
  int         width;
  logic [8:0] frame_bits;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    bus_read(2'd1, rd);
    check("reset_status", 16'(rd), 16'h0010);
    check("reset_txd", 16'(txd), 16'h0001);
    check("reset_irq", 16'(irq), 16'h0000);

    // transmit 0xA5 at 19200
    bus_write(2'd3, 8'h1F);
    bus_write(2'd2, 8'h05);
    check("irq_tdre_enabled", 16'(irq), 16'h0001);
    bus_write(2'd0, 8'hA5);
    check("irq_after_write", 16'(irq), 16'h0000);
    check("txd_idle_after_write", 16'(txd), 16'h0001);
    wait_txd_low(found);
    check("tx_start_seen", 16'(found), 16'h0001);
    check("irq_at_frame_start", 16'(irq), 16'h0001);
    width = 1;
    while (txd === 1'b0 && width < 1000) begin
      @(negedge clk);
      if (txd === 1'b0) width++;
    end
    check("tx_start_width", 16'(width), 16'(TX_BIT));
    frame_bits = 9'b1_1010_0101;
    for (int i = 0; i < 9; i++) begin
      repeat (TX_BIT / 2) @(negedge clk);
      check($sformatf("tx_bit%0d", i), 16'(txd), 16'(frame_bits[i]));
      repeat (TX_BIT / 2) @(negedge clk);
    end

    // receive 0x3C at 9600
    bus_write(2'd3, 8'h1E);
    bus_write(2'd2, 8'h09);
    check("irq_rx_idle", 16'(irq), 16'h0000);
    send_rx(8'h3C, 1'b1);
    check("irq_rdrf", 16'(irq), 16'h0001);
    bus_read(2'd1, rd);
    check("status_rdrf", 16'(rd), 16'h0098);
    bus_read(2'd0, rd);
    check("rx_data_3c", 16'(rd), 16'h003C);
    bus_read(2'd1, rd);
    check("status_after_read", 16'(rd), 16'h0010);
    check("irq_after_read", 16'(irq), 16'h0000);

    // overrun: second byte dropped, first kept
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus_read(2'd1, rd);
    check("status_overrun", 16'(rd), 16'h009C);
    bus_read(2'd0, rd);
    check("rx_data_11", 16'(rd), 16'h0011);
    bus_read(2'd1, rd);
    check("status_overrun_cleared", 16'(rd), 16'h0010);

    // framing error on a low stop bit
    send_rx(8'h55, 1'b0);
    bus_read(2'd1, rd);
    check("status_framing", 16'(rd), 16'h009A);
    bus_read(2'd0, rd);
    check("rx_data_55", 16'(rd), 16'h0055);
    bus_read(2'd1, rd);
    check("status_framing_cleared", 16'(rd), 16'h0010);

    // 600 ns low glitch is rejected at the start-bit centre sample
    rxd = 1'b0;
    #600;
    rxd = 1'b1;
    repeat (1000) @(negedge clk);
    bus_read(2'd1, rd);
    check("status_after_glitch", 16'(rd), 16'h0010);

    // reset in the middle of data bit 3 of 0xF0 (bit 3 = 0)
    bus_write(2'd3, 8'h1F);
    bus_write(2'd2, 8'h05);
    bus_write(2'd0, 8'hF0);
    wait_txd_low(found);
    check("tx2_start_seen", 16'(found), 16'h0001);
    repeat (TX_BIT * 4 + TX_BIT / 2) @(negedge clk);
    check("tx2_bit3_low", 16'(txd), 16'h0000);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("txd_after_reset", 16'(txd), 16'h0001);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus_read(2'd1, rd);
    check("status_after_reset", 16'(rd), 16'h0010);
    check("irq_after_reset", 16'(irq), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
